noc_vc_buffer: RTL

Input-side virtual-channel buffer stage of the NoC router. It sits directly downstream of the switch controller, which supplies each routed flit together with a VC select. The block stores each flit in a per-VC FIFO and arbitrates between VCs at packet granularity. It then drives the downstream link with a registered flit under ready/valid backpressure.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/vc_fifo.sv | 54 +++++
 rtl/noc_vc_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit encodings and VC indices
// Used by the switch controller and the VC buffer stage.
package noc_pkg;
    localparam int FLIT_W = 8;
    localparam int NODE_W = 2;
    localparam int VC_W   = 2;

    localparam logic [5:0]        HEAD_TAG = 6'b101111;
    localparam logic [FLIT_W-1:0] TRAILER  = 8'hFF;
    localparam logic [FLIT_W-1:0] IDLE     = 8'h00;

    localparam logic [VC_W-1:0] VC_EJECT = 2'd0;
    localparam logic [VC_W-1:0] VC_FWD   = 2'd1;
    localparam logic [VC_W-1:0] VC_INJ   = 2'd2;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    function automatic logic is_head(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1:NODE_W] == HEAD_TAG;
    endfunction
endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - per-VC flit FIFO with head peek
// Caller guarantees no write when full and no pop when empty.
module vc_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [FLIT_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [FLIT_W-1:0] head_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({wr_en_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/noc_vc_buffer.sv
// rtl/noc_vc_buffer.sv - per-VC flit buffering, packet-locked VC arbiter, output register
// Packets from different VCs never interleave on flit_out_down.
module noc_vc_buffer
    import noc_pkg::*;
#(
    parameter int NUM_VC = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic [VC_W-1:0]   vc_sel,
    output logic [NUM_VC-1:0] vc_full,
    output logic [FLIT_W-1:0] flit_out_down,
    output logic [VC_W-1:0]   out_vc,
    input  logic              down_ready,
    output logic              ovf_err
);
    logic [NUM_VC-1:0] wr_en, pop, empty;
    logic [FLIT_W-1:0] head [NUM_VC];

    arb_state_e        state_q, state_d;
    logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
    logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic [VC_W-1:0]   out_vc_q, out_vc_d;
    logic              ovf_q, ovf_d;

    logic              load, pop_any;
    logic [VC_W-1:0]   pop_vc;
    logic [FLIT_W-1:0] pop_flit;
    int                idx;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (wr_en[v]),
            .wr_data_i (flit_in),
            .pop_i     (pop[v]),
            .full_o    (vc_full[v]),
            .empty_o   (empty[v]),
            .head_o    (head[v])
        );
    end

    // Full check uses start-of-cycle occupancy, so a same-cycle pop never rescues a write.
    always_comb begin
        wr_en = '0;
        ovf_d = ovf_q;
        if (flit_in != IDLE) begin
            if (int'(vc_sel) >= NUM_VC) ovf_d = 1'b1;
            for (int v = 0; v < NUM_VC; v++) begin
                if (vc_sel == VC_W'(v)) begin
                    if (vc_full[v]) ovf_d = 1'b1;
                    else            wr_en[v] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        load      = (flit_q == IDLE) || down_ready;
        pop       = '0;
        pop_any   = 1'b0;
        pop_vc    = lock_vc_q;
        idx       = 0;
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        if (state_q == ARB_LOCKED) begin
            pop_any = !empty[lock_vc_q];
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                idx = (int'(rr_ptr_q) + i) % NUM_VC;
                if (!pop_any && !empty[idx] && is_head(head[idx])) begin
                    pop_any = 1'b1;
                    pop_vc  = VC_W'(idx);
                end
            end
        end
        pop_any  = pop_any && load;
        pop_flit = head[pop_vc];
        if (pop_any) begin
            pop[pop_vc] = 1'b1;
            if (state_q == ARB_UNLOCKED) begin
                state_d   = ARB_LOCKED;
                lock_vc_d = pop_vc;
                rr_ptr_d  = VC_W'((int'(pop_vc) + 1) % NUM_VC);
            end
            if (pop_flit == TRAILER) state_d = ARB_UNLOCKED;
        end
        flit_d   = flit_q;
        out_vc_d = out_vc_q;
        if (load) begin
            flit_d = pop_any ? pop_flit : IDLE;
            if (pop_any) out_vc_d = pop_vc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_UNLOCKED;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            flit_q    <= IDLE;
            out_vc_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            flit_q    <= flit_d;
            out_vc_q  <= out_vc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign flit_out_down = flit_q;
    assign out_vc        = out_vc_q;
    assign ovf_err       = ovf_q;
endmodule
